squash_merger: RTL and testbench
================================

// Module: squash_merger
// PURPOSE
//  Consumer side of the difftest squash-enable signal. Sits between core commit
//  probes and the DPI-C commit bridge. While enable=1 it merges consecutive
//  ordinary commit events into one accumulated event (count + last PC), cutting
//  DPI call rate. Special events (exception/interrupt/skip) and enable=0 bypass
//  merging, so instruction-exact checking resumes.
// PARAMETERS
//  MAX_SQUASH  32    max instructions merged into one output event (>= 8)
//  CNT_W       8     width of count fields; must hold MAX_SQUASH
//  TIMEOUT     1024  cycles a non-empty accumulator may wait before forced flush (>= 2)
// PORTS
//  clock        in   1      single clock
//  reset        in   1      asynchronous, active-low reset (asserted at 0)
//  enable       in   1      squash enable from squash control; 1 = merge allowed
//  in_valid     in   1      commit event valid
//  in_ready     out  1      event accepted when in_valid && in_ready
//  in_n         in   3      instructions in event, 1..6
//  in_pc        in   64     PC of last instruction in event
//  in_special   in   1      event must not be merged
//  out_valid    out  1      output event valid; held until out_ready
//  out_ready    in   1      DPI bridge accepts output event
//  out_cnt      out  CNT_W  instructions represented by output event
//  out_pc       out  64     PC of last instruction in output event
//  out_special  out  1      output event is a special pass-through
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low.
//  - Reset asserted (any time, including mid-accumulation): out_valid=0,
//    out_cnt=0, out_pc=0, out_special=0, accumulator empty, timer=0. Pending
//    contents are discarded.
//  - State: single-entry output register (out_*); accumulator (acc_valid,
//    acc_cnt, acc_pc); timer (clog2(TIMEOUT) bits).
//  - out_free = !out_valid || out_ready. out_* stays stable while
//    out_valid && !out_ready.
//  - flush_trig = acc_valid && (!enable || acc_cnt==MAX_SQUASH ||
//    timer==TIMEOUT-1 || (in_valid && (in_special || acc_cnt+in_n > MAX_SQUASH))).
//    Compute the sum in CNT_W+1 bits.
//  - Flush: if flush_trig && out_free, the accumulator moves to out_* on the
//    next edge with out_special=0. The accumulator clears and the timer resets.
//    in_ready=0 in the flush cycle.
//  - in_ready = !flush_trig && (merge_path || out_free).
//    merge_path = enable && !in_special. in_ready may depend on in_special and
//    in_n but never on out_* data.
//  - Accepted merge_path event: if acc empty, set acc_cnt=in_n and timer=0.
//    Otherwise acc_cnt += in_n. In both cases acc_pc=in_pc.
//  - Accepted non-merge event: the accumulator is empty by construction. The
//    event loads out_* next edge with out_cnt=in_n, out_pc=in_pc,
//    out_special=in_special. Latency is 1 cycle.
//  - Timer increments every cycle while acc_valid and saturates at TIMEOUT-1.
//  - Accepted event with in_n=0 is dropped with no state change.
//  - Output order always equals input order. An accumulated event precedes any
//    later special or pass-through event.
// TESTING
//  1. enable=1, out_ready=1: 10 events in_n=1, pc=0x8000_0000+4k, k=0..9. Drop
//     enable at T -> exactly one output, cnt=10, pc=0x8000_0024, out_valid at T+1.
//  2. MAX_SQUASH=32: 12 back-to-back events in_n=3. The 11th stalls 1 cycle
//     (in_ready=0) while cnt=30 emits. Then enable=0 -> second output cnt=6.
//  3. acc_cnt=5, then special pc=0x8000_1000, in_n=1 -> out cnt=5 special=0,
//     next cycle out cnt=1, pc=0x8000_1000, special=1.
//  4. TIMEOUT=16: one event in_n=2 then idle -> out_valid exactly 16 cycles after
//     accept, cnt=2.
//  5. out_ready=0 with out_valid=1: out_* stable. Merges continue until
//     acc_cnt=MAX_SQUASH, then in_ready=0. Raising out_ready drains in order.
//  6. enable=0: each event appears 1 cycle after accept with cnt=in_n.
//     reset=0 mid-accumulation -> out_valid=0 immediately, nothing emitted later.

Source files
------------

// File: rtl/squash_merger.sv
// squash_merger: merges consecutive ordinary commit events into one
// accumulated event (count + last PC) while squash is enabled. Special
// events and enable=0 bypass the accumulator so checking is per-instruction.
module squash_merger #(
  parameter int unsigned MAX_SQUASH = 32,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_n,
  input  logic [63:0]      in_pc,
  input  logic             in_special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic [63:0]      out_pc,
  output logic             out_special
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_cnt;
  logic [63:0]      r_out_pc;
  logic             r_out_special;

  logic             r_acc_valid;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [63:0]      r_acc_pc;
  logic [TW-1:0]    r_timer;

  logic             w_out_free;
  logic [CNT_W:0]   w_sum;
  logic             w_timer_max;
  logic             w_flush_trig;
  logic             w_flush;
  logic             w_merge_path;
  logic             w_in_ready;
  logic             w_accept;

  // Flush decision, input handshake and accept qualification
  always_comb begin
    w_out_free   = !r_out_valid || out_ready;
    w_sum        = {1'b0, r_acc_cnt} + (CNT_W+1)'(in_n);
    w_timer_max  = (r_timer == TW'(TIMEOUT - 1));
    w_flush_trig = r_acc_valid &&
                   (!enable ||
                    (r_acc_cnt == CNT_W'(MAX_SQUASH)) ||
                    w_timer_max ||
                    (in_valid && (in_special || (w_sum > (CNT_W+1)'(MAX_SQUASH)))));
    w_flush      = w_flush_trig && w_out_free;
    w_merge_path = enable && !in_special;
    w_in_ready   = !w_flush_trig && (w_merge_path || w_out_free);
    // Zero-length events are consumed without touching any state
    w_accept     = in_valid && w_in_ready && (in_n != 3'd0);
  end

  // Output register, accumulator and age timer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_out_cnt     <= '0;
      r_out_pc      <= '0;
      r_out_special <= 1'b0;
      r_acc_valid   <= 1'b0;
      r_acc_cnt     <= '0;
      r_acc_pc      <= '0;
      r_timer       <= '0;
    end else begin
      if (w_flush) begin
        r_out_valid   <= 1'b1;
        r_out_cnt     <= r_acc_cnt;
        r_out_pc      <= r_acc_pc;
        r_out_special <= 1'b0;
      end else if (w_accept && !w_merge_path) begin
        r_out_valid   <= 1'b1;
        r_out_cnt     <= CNT_W'(in_n);
        r_out_pc      <= in_pc;
        r_out_special <= in_special;
      end else if (out_ready) begin
        r_out_valid   <= 1'b0;
      end

      if (w_flush) begin
        r_acc_valid <= 1'b0;
        r_acc_cnt   <= '0;
        r_timer     <= '0;
      end else begin
        if (r_acc_valid && !w_timer_max) begin
          r_timer <= r_timer + TW'(1);
        end
        if (w_accept && w_merge_path) begin
          if (!r_acc_valid) begin
            r_acc_valid <= 1'b1;
            r_acc_cnt   <= CNT_W'(in_n);
            r_timer     <= '0;
          end else begin
            r_acc_cnt   <= r_acc_cnt + CNT_W'(in_n);
          end
          r_acc_pc <= in_pc;
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_cnt     = r_out_cnt;
  assign out_pc      = r_out_pc;
  assign out_special = r_out_special;

endmodule

// File: tb/tb_squash_merger.sv
// Bench for squash_merger: directed scenarios plus random traffic, checked
// by a transaction-level group model feeding an expected-output queue.
module tb_squash_merger;

  localparam int unsigned MAXS = 32;
  localparam int unsigned CW   = 8;
  localparam int unsigned TO   = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_n = 3'd0;
  logic [63:0]   in_pc = 64'd0;
  logic          in_special = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_cnt;
  logic [63:0]   out_pc;
  logic          out_special;

  always #5 clock = ~clock;

  squash_merger #(.MAX_SQUASH(MAXS), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_pc(in_pc),
    .in_special(in_special), .out_valid(out_valid), .out_ready(out_ready),
    .out_cnt(out_cnt), .out_pc(out_pc), .out_special(out_special)
  );

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [63:0]   pc;
    logic          sp;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  bit          rnd_ready = 1'b0;

  // Reference model: one open merge group plus its age in cycles
  bit          g_open = 1'b0;
  int          g_cnt  = 0;
  logic [63:0] g_pc   = 64'd0;
  int          g_age  = 0;
  bit          g_new;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input int cnt, input logic [63:0] pc, input logic sp);
    ev_t e;
    e.cnt = CW'(cnt);
    e.pc  = pc;
    e.sp  = sp;
    return e;
  endfunction

  // Monitor: compare presented outputs to the queue head, then advance the model
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      g_open = 1'b0;
      g_cnt  = 0;
      g_age  = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual cnt=%0d pc=%0h required=none", out_cnt, out_pc);
          if (out_ready) n_out++;
        end else begin
          chk("out_cnt", 64'(out_cnt), 64'(exp_q[0].cnt));
          chk("out_pc", out_pc, exp_q[0].pc);
          chk("out_special", 64'(out_special), 64'(exp_q[0].sp));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      // A group closes when merging stops, it is full, it is too old,
      // or the offered event cannot join it
      if (g_open && (!enable || g_cnt == int'(MAXS) || g_age == int'(TO) - 1 ||
                     (in_valid && (in_special || g_cnt + int'(in_n) > int'(MAXS))))) begin
        exp_q.push_back(mk(g_cnt, g_pc, 1'b0));
        g_open = 1'b0;
      end
      g_new = 1'b0;
      if (in_valid && in_ready && in_n != 3'd0) begin
        if (enable && !in_special) begin
          if (!g_open) begin
            g_open = 1'b1;
            g_cnt  = int'(in_n);
            g_age  = 0;
            g_new  = 1'b1;
          end else begin
            g_cnt  = g_cnt + int'(in_n);
          end
          g_pc = in_pc;
        end else begin
          exp_q.push_back(mk(int'(in_n), in_pc, in_special));
        end
      end
      if (g_open && !g_new && g_age < int'(TO) - 1) g_age = g_age + 1;
    end
  end

  // Random backpressure; always ready while merging is disabled
  always @(posedge clock) begin
    if (rnd_ready) begin
      #2;
      out_ready = enable ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Offer one event and hold it until accepted; returns refused cycles
  task automatic send(input logic [2:0] n, input logic [63:0] pc, input logic sp, output int stall);
    bit done;
    done       = 1'b0;
    stall      = 0;
    in_valid   = 1'b1;
    in_n       = n;
    in_pc      = pc;
    in_special = sp;
    while (!done) begin
      @(negedge clock);
      done = in_ready;
      step();
      if (!done) begin
        stall++;
        if (stall >= 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout actual=%0d required<200", stall);
          done = 1'b1;
        end
      end
    end
    in_valid   = 1'b0;
    in_n       = 3'd0;
    in_special = 1'b0;
  endtask

  initial begin
    int st;
    int base;
    int k;
    bit seen;
    int gap;
    logic [2:0] n;

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_special", 64'(out_special), 64'd0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // Ten single-instruction events merge into one; flush follows enable drop
    enable = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 10; i++) send(3'd1, 64'h8000_0000 + 64'(4 * i), 1'b0, st);
    enable = 1'b0;
    @(negedge clock);
    chk("t1_valid_at_T", 64'(out_valid), 64'd0);
    step();
    @(negedge clock);
    chk("t1_valid_at_T1", 64'(out_valid), 64'd1);
    chk("t1_cnt", 64'(out_cnt), 64'd10);
    chk("t1_pc", out_pc, 64'h8000_0024);
    idle(5);
    chk("t1_outputs", 64'(n_out - base), 64'd1);

    // Overflow: 11th event of 3 stalls while the 30-group leaves
    enable = 1'b1;
    base = n_out;
    for (int i = 0; i < 12; i++) begin
      send(3'd3, 64'h8000_2000 + 64'(4 * i), 1'b0, st);
      chk((i == 10) ? "t2_stall_11th" : "t2_no_stall", 64'(st), (i == 10) ? 64'd1 : 64'd0);
    end
    enable = 1'b0;
    idle(4);
    chk("t2_outputs", 64'(n_out - base), 64'd2);

    // Special event flushes the group ahead of itself
    enable = 1'b1;
    base = n_out;
    send(3'd5, 64'h8000_0100, 1'b0, st);
    send(3'd1, 64'h8000_1000, 1'b1, st);
    chk("t3_special_stall", 64'(st), 64'd1);
    idle(4);
    chk("t3_outputs", 64'(n_out - base), 64'd2);

    // Age timeout
    send(3'd2, 64'h8000_3000, 1'b0, st);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
      else begin
        step();
        k++;
      end
    end
    chk("t4_latency", 64'(k), 64'd16);
    chk("t4_cnt", 64'(out_cnt), 64'd2);
    idle(3);

    // Backpressure: output held, merges fill to the limit, then input blocks
    base = n_out;
    out_ready = 1'b0;
    send(3'd3, 64'h8000_4000, 1'b1, st);
    for (int i = 0; i < 8; i++) begin
      send(3'd4, 64'h8000_5000 + 64'(4 * i), 1'b0, st);
      chk("t5_merge_no_stall", 64'(st), 64'd0);
    end
    in_valid = 1'b1;
    in_n = 3'd4;
    in_pc = 64'h8000_6000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t5_blocked", 64'(in_ready), 64'd0);
      chk("t5_hold_cnt", 64'(out_cnt), 64'd3);
      step();
    end
    out_ready = 1'b1;
    send(3'd4, 64'h8000_6000, 1'b0, st);
    enable = 1'b0;
    idle(4);
    chk("t5_outputs", 64'(n_out - base), 64'd3);

    // Pass-through with merging disabled: one cycle latency
    for (int i = 0; i < 4; i++) begin
      n = 3'(i + 1);
      send(n, 64'h8000_7000 + 64'(8 * i), 1'b0, st);
      @(negedge clock);
      chk("t6_valid", 64'(out_valid), 64'd1);
      chk("t6_cnt", 64'(out_cnt), 64'(n));
      step();
    end

    // Reset mid-accumulation with a held output
    enable = 1'b1;
    out_ready = 1'b0;
    send(3'd1, 64'h8000_8000, 1'b1, st);
    send(3'd2, 64'h8000_8004, 1'b0, st);
    send(3'd3, 64'h8000_8008, 1'b0, st);
    base = n_out;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_cnt", 64'(out_cnt), 64'd0);
    idle(2);
    reset = 1'b1;
    out_ready = 1'b1;
    idle(40);
    chk("t6_after_reset", 64'(n_out - base), 64'd0);

    // Random traffic
    enable = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if (enable) begin
          enable = 1'b0;
          idle(2);
        end else begin
          enable = 1'b1;
        end
      end
      send(3'($urandom_range(0, 6)), {$urandom, $urandom}, ($urandom_range(0, 9) == 0), st);
      k = int'($urandom_range(0, 19));
      gap = (k == 0) ? 20 : (k < 10) ? 0 : int'($urandom_range(1, 3));
      idle(gap);
    end
    rnd_ready = 1'b0;
    enable = 1'b0;
    step();
    out_ready = 1'b1;
    idle(30);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
